fetch_byte_queue: RTL

//  Byte queue between the Sysbus fetch path and the x86-64 instruction decoder.
//  - Accepts 8-byte aligned fetch words.
//  - Presents the next 15 instruction bytes as a window in the decoder's buffer

---
 rtl/decode_pkg.sv | 20 ++
 rtl/byte_window_rot.sv | 32 +++
 rtl/fetch_byte_queue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pkg
//  Brief    : Shared constants and types for the fetch/decode front end.
//  Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam int MAX_INST_BYTES = 15;
    localparam int FETCH_BYTES    = 8;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } fetch_state_t;

    typedef logic [0:MAX_INST_BYTES*8-1] inst_window_t;

endpackage
`default_nettype wire

// File: rtl/byte_window_rot.sv
`default_nettype none
// ============================================================================
//  Module   : byte_window_rot
//  Brief    : Circular read of MAX_INST_BYTES bytes starting at head,
//             with bytes at or beyond count forced to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_window_rot
    import decode_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
)(
    input  logic [7:0]    mem [DEPTH],
    input  logic [AW-1:0] head,
    input  logic [CW-1:0] count,
    output inst_window_t  window
);

    // Rotate storage so byte 0 of the window sits at head; mask empty slots.
    always_comb begin
        window = '0;
        for (int i = 0; i < MAX_INST_BYTES; i++) begin
            if (CW'(i) < count) begin
                window[i*8 +: 8] = mem[head + AW'(i)];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_byte_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_byte_queue
//  Brief    : Byte queue between the fetch path and the instruction decoder.
//             Accepts aligned 8-byte fetch words, presents a 15-byte decode
//             window, retires consumed bytes and tracks fetch/decode PCs.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_byte_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int PC_W  = 64
)(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    output logic [PC_W-1:0] fetch_addr,
    input  logic            fill_valid,
    output logic            fill_ready,
    input  logic [63:0]     fill_data,
    output inst_window_t    window,
    output logic [3:0]      win_count,
    output logic            win_full,
    input  logic            consume,
    input  logic [3:0]      consume_len,
    output logic [PC_W-1:0] decode_pc,
    output logic            err_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FILL_LIMIT = CW'(DEPTH - FETCH_BYTES);
    localparam logic [CW-1:0] WIN_BYTES  = CW'(MAX_INST_BYTES);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [2:0]    skip;
    fetch_state_t  fstate;

    logic [2:0]    eff_skip;
    logic          fill_acc;
    logic [CW-1:0] fill_bytes;
    logic [CW-1:0] len_ext;
    logic          len_ok;
    logic          cons_ok;
    logic          cons_bad;
    logic [CW-1:0] cons_bytes;
    logic [AW-1:0] wr_idx [FETCH_BYTES];
    logic          wr_en  [FETCH_BYTES];

    // Readiness looks only at the pre-consume occupancy so a word is never
    // accepted on the strength of bytes being retired in the same cycle.
    assign fill_ready = (count <= FILL_LIMIT);

    // Leading-byte skip applies only to the first word after a redirect.
    assign eff_skip   = (fstate == REDIRECT) ? skip : 3'd0;
    assign fill_acc   = fill_valid && fill_ready && !flush;
    assign fill_bytes = fill_acc ? CW'(4'(FETCH_BYTES) - {1'b0, eff_skip}) : '0;

    assign len_ext    = CW'(consume_len);
    assign len_ok     = (consume_len != 4'd0) && (len_ext <= count);
    assign cons_ok    = consume && !flush && len_ok;
    assign cons_bad   = consume && !flush && !len_ok;
    assign cons_bytes = cons_ok ? len_ext : '0;

    assign win_full  = (count >= WIN_BYTES);
    assign win_count = win_full ? 4'(MAX_INST_BYTES) : count[3:0];

    // Per-byte write slot: bytes below the skip point are discarded and the
    // remainder pack contiguously from tail.
    always_comb begin
        for (int k = 0; k < FETCH_BYTES; k++) begin
            wr_idx[k] = tail + AW'(k) - AW'(eff_skip);
            wr_en[k]  = fill_acc && (3'(k) >= eff_skip);
        end
    end

    // Byte storage; contents beyond count are never observed, so no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_BYTES; k++) begin
            if (wr_en[k]) begin
                mem[wr_idx[k]] <= fill_data[8*k +: 8];
            end
        end
    end

    // Queue pointers, PCs, redirect FSM and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            skip        <= 3'd0;
            fetch_addr  <= '0;
            decode_pc   <= '0;
            err_overrun <= 1'b0;
            fstate      <= RUN;
        end else begin
            if (flush) begin
                count      <= '0;
                head       <= '0;
                tail       <= '0;
                decode_pc  <= flush_pc;
                fetch_addr <= {flush_pc[PC_W-1:3], 3'b000};
                skip       <= flush_pc[2:0];
                fstate     <= REDIRECT;
            end else begin
                count <= count + fill_bytes - cons_bytes;
                if (fill_acc) begin
                    tail       <= tail + fill_bytes[AW-1:0];
                    fetch_addr <= fetch_addr + PC_W'(FETCH_BYTES);
                    skip       <= 3'd0;
                    fstate     <= RUN;
                end
                if (cons_ok) begin
                    head      <= head + len_ext[AW-1:0];
                    decode_pc <= decode_pc + PC_W'(consume_len);
                end
            end
            if (cons_bad) begin
                err_overrun <= 1'b1;
            end
        end
    end

    byte_window_rot #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) u_rot (
        .mem    (mem),
        .head   (head),
        .count  (count),
        .window (window)
    );

endmodule
`default_nettype wire
